// File: rtl/instr_mem_pkg.sv
// ---------------------------------------------------------------------------
// instr_mem_pkg
//   Shared constants and address-decoding helpers for the instruction fetch
//   memory. Addresses are widened to a fixed maximum width so the helpers can
//   serve any ADDR_W up to MAX_ADDR_W without per-instance copies.
// ---------------------------------------------------------------------------
package instr_mem_pkg;

  localparam int unsigned MAX_ADDR_W = 64;

  typedef logic [MAX_ADDR_W-1:0] addr_max_t;

  // Default instruction returned on error and after reset.
  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

  // Number of low address bits that select a byte within a word.
  function automatic int unsigned lsb_bits(input int unsigned data_w,
                                           input bit byte_addr);
    return byte_addr ? $clog2(data_w / 8) : 0;
  endfunction

  // Full-width word index; bits above the array index are kept so the caller
  // can range-check them rather than wrapping around.
  function automatic addr_max_t word_index(input addr_max_t   addr,
                                           input bit          byte_addr,
                                           input int unsigned data_w);
    return addr >> lsb_bits(data_w, byte_addr);
  endfunction

  // Non-zero byte-offset bits mean the address is not word aligned.
  function automatic logic is_misaligned(input addr_max_t   addr,
                                         input bit          byte_addr,
                                         input int unsigned data_w);
    addr_max_t mask;
    mask = (addr_max_t'(1) << lsb_bits(data_w, byte_addr)) - addr_max_t'(1);
    return (addr & mask) != '0;
  endfunction

endpackage

// File: rtl/instr_mem_array.sv
// ---------------------------------------------------------------------------
// instr_mem_array
//   DEPTH x DATA_W storage with one synchronous read port and one write port.
//   A read and a write to the same index on the same edge return the old word.
//   Contents are never reset so the array maps onto block RAM.
// Ports
//   clk        clock, rising edge
//   i_rd_en    load the read register from i_rd_idx
//   i_rd_idx   read index
//   o_rd_data  registered read data, holds while i_rd_en is low
//   i_wr_en    write strobe
//   i_wr_idx   write index
//   i_wr_data  write data
// ---------------------------------------------------------------------------
module instr_mem_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_rd_en,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [DATA_W-1:0] i_wr_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // Both accesses in one block with non-blocking writes gives read-before-write.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_idx];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/instr_fetch_mem.sv
// ---------------------------------------------------------------------------
// instr_fetch_mem
//   Programmable instruction memory for the fetch stage. Fetch requests arrive
//   on a valid/ready channel and the word is returned one cycle later on a
//   valid/ready response channel. Misaligned and out-of-range fetches return
//   NOP_WORD with rsp_err set. A program port writes the array independently,
//   and flush drops the held response and blocks acceptance for that cycle.
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   req_valid/ready/addr fetch request channel
//   rsp_valid/ready      response channel handshake
//   rsp_instr            fetched word (NOP_WORD on error)
//   rsp_addr, rsp_err    echoed request address, error flag
//   prog_we/addr/data    program-port write
//   flush                discard held response, accept nothing this cycle
// ---------------------------------------------------------------------------
module instr_fetch_mem
  import instr_mem_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       DEPTH     = 64,
  parameter int unsigned       ADDR_W    = 32,
  parameter bit                BYTE_ADDR = 1'b1,
  parameter logic [DATA_W-1:0] NOP_WORD  = DATA_W'(NOP_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_err,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              flush
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  // Address decode for both ports
  addr_max_t        w_req_full_idx;
  addr_max_t        w_prog_full_idx;
  logic [IDX_W-1:0] w_req_idx;
  logic [IDX_W-1:0] w_prog_idx;
  logic             w_req_err;
  logic             w_prog_ok;
  logic             w_req_accept;
  logic [DATA_W-1:0] w_ram_q;

  // Response registers
  logic              r_rsp_valid;
  logic [ADDR_W-1:0] r_rsp_addr;
  logic              r_rsp_err;
  // Set when the last accepted fetch read the array; otherwise the response
  // carries NOP_WORD. This keeps the array read register free of reset.
  logic              r_from_ram;

  assign w_req_full_idx  = word_index(addr_max_t'(req_addr), BYTE_ADDR, DATA_W);
  assign w_prog_full_idx = word_index(addr_max_t'(prog_addr), BYTE_ADDR, DATA_W);
  assign w_req_idx       = w_req_full_idx[IDX_W-1:0];
  assign w_prog_idx      = w_prog_full_idx[IDX_W-1:0];

  // Range check uses the full index so high address bits never alias.
  assign w_req_err = is_misaligned(addr_max_t'(req_addr), BYTE_ADDR, DATA_W) ||
                     (w_req_full_idx >= addr_max_t'(DEPTH));
  assign w_prog_ok = !is_misaligned(addr_max_t'(prog_addr), BYTE_ADDR, DATA_W) &&
                     (w_prog_full_idx < addr_max_t'(DEPTH));

  assign req_ready    = !flush && (!r_rsp_valid || rsp_ready);
  assign w_req_accept = req_valid && req_ready;

  instr_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk       (clk),
    .i_rd_en   (w_req_accept && !w_req_err),
    .i_rd_idx  (w_req_idx),
    .o_rd_data (w_ram_q),
    .i_wr_en   (prog_we && w_prog_ok),
    .i_wr_idx  (w_prog_idx),
    .i_wr_data (prog_data)
  );

  // Accept excludes flush, so a flush edge always falls through to clearing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_addr  <= '0;
      r_rsp_err   <= 1'b0;
      r_from_ram  <= 1'b0;
    end else if (w_req_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_addr  <= req_addr;
      r_rsp_err   <= w_req_err;
      r_from_ram  <= !w_req_err;
    end else if (flush || rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_addr  = r_rsp_addr;
  assign rsp_err   = r_rsp_err;
  assign rsp_instr = r_from_ram ? w_ram_q : NOP_WORD;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_mem
//   Self-checking bench for instr_fetch_mem: vector table for back-to-back and
//   error fetches, hand-written stall / collision / flush / reset sequences,
//   then randomized traffic against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_instr_fetch_mem;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned DEP   = 64;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_instr;
  logic [AW-1:0] rsp_addr;
  logic          rsp_err;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] prog_data;
  logic          flush;

  int checks;
  int failures;

  // Reference memory image (word addressed)
  logic [31:0] mdl_mem [DEP];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  vec_t vecs [8];

  instr_fetch_mem #(
    .DATA_W    (DW),
    .DEPTH     (DEP),
    .ADDR_W    (AW),
    .BYTE_ADDR (1'b1),
    .NOP_WORD  (NOP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_addr  (rsp_addr),
    .rsp_err   (rsp_err),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .flush     (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    return (a % 4 == 0) && (a / 4 < DEP);
  endfunction

  task automatic prog(input logic [31:0] a, input logic [31:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    cyc();
    prog_we = 1'b0;
    if (addr_ok(a)) mdl_mem[a / 4] = d;
    $display("prog  addr=%h data=%h", a, d);
  endtask

  task automatic fetch_check(input string name, input logic [31:0] a,
                             input logic [31:0] exp, input logic exp_err);
    req_valid = 1'b1;
    req_addr  = a;
    rsp_ready = 1'b1;
    cyc();
    req_valid = 1'b0;
    @(negedge clk);
    chk1(name, rsp_valid, 1'b1);
    chk32(name, rsp_instr, exp);
    chk1(name, rsp_err, exp_err);
    $display("fetch addr=%h instr=%h err=%b", a, rsp_instr, rsp_err);
    cyc();
  endtask

  logic [31:0] init_words [6];

  // Model state for the random phase
  logic        pv;
  logic [31:0] pi, pa;
  logic        pe;
  logic        exp_rdy;

  initial begin
    checks = 0; failures = 0;
    init_words[0] = 32'h0062_0000; init_words[1] = 32'h0064_0000;
    init_words[2] = 32'h00A6_0000; init_words[3] = 32'h00E6_1000;
    init_words[4] = 32'h012A_1800; init_words[5] = 32'h016C_0000;
    for (int i = 0; i < 6; i++) vecs[i] = '{32'(i * 4), init_words[i], 1'b0};
    vecs[6] = '{32'(4 * DEP), NOP, 1'b1};
    vecs[7] = '{32'd6, NOP, 1'b1};
    for (int i = 0; i < int'(DEP); i++) mdl_mem[i] = 32'h0;

    rst_n = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0; flush = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk1("reset_valid", rsp_valid, 1'b0);
    chk32("reset_instr", rsp_instr, NOP);
    chk32("reset_addr", rsp_addr, 32'h0);
    chk1("reset_err", rsp_err, 1'b0);
    chk1("reset_ready", req_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < 6; i++) prog(32'(i * 4), init_words[i]);

    // Back-to-back vector table, one response per cycle
    rsp_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        req_valid = 1'b1;
        req_addr  = vecs[i].addr;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      if (i > 0) begin
        chk1("tbl_valid", rsp_valid, 1'b1);
        chk32("tbl_instr", rsp_instr, vecs[i-1].instr);
        chk32("tbl_addr", rsp_addr, vecs[i-1].addr);
        chk1("tbl_err", rsp_err, vecs[i-1].err);
        $display("fetch addr=%h instr=%h err=%b", rsp_addr, rsp_instr, rsp_err);
      end
      if (i < 8) chk1("tbl_ready", req_ready, 1'b1);
      cyc();
    end
    @(negedge clk);
    chk1("tbl_drained", rsp_valid, 1'b0);
    cyc();

    // Ignored program writes: out of range (would alias index 0) and misaligned
    prog(32'(4 * DEP), 32'hBAD0_0001);
    prog(32'd5, 32'hBAD0_0002);
    fetch_check("ign_oor", 32'd0, init_words[0], 1'b0);
    fetch_check("ign_mis", 32'd4, init_words[1], 1'b0);

    // Stall on addr 8 for 3 cycles with the next fetch waiting
    req_valid = 1'b1; req_addr = 32'd8; rsp_ready = 1'b0;
    cyc();
    req_addr = 32'd16;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("stall_valid", rsp_valid, 1'b1);
      chk32("stall_instr", rsp_instr, 32'h00A6_0000);
      chk32("stall_addr", rsp_addr, 32'd8);
      chk1("stall_ready", req_ready, 1'b0);
      cyc();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk1("stall_release_ready", req_ready, 1'b1);
    cyc();
    req_valid = 1'b0;
    @(negedge clk);
    chk32("stall_next_addr", rsp_addr, 32'd16);
    chk32("stall_next_instr", rsp_instr, 32'h012A_1800);
    $display("stall released, next fetch addr=%h instr=%h", rsp_addr, rsp_instr);
    cyc();
    @(negedge clk);
    chk1("drain_valid", rsp_valid, 1'b0);
    chk32("drain_hold_instr", rsp_instr, 32'h012A_1800);
    chk32("drain_hold_addr", rsp_addr, 32'd16);
    cyc();

    // Same-edge write and fetch: old word first, new word afterwards
    prog_we = 1'b1; prog_addr = 32'd12; prog_data = 32'hDEAD_BEEF;
    req_valid = 1'b1; req_addr = 32'd12; rsp_ready = 1'b1;
    cyc();
    prog_we = 1'b0; req_valid = 1'b0;
    mdl_mem[3] = 32'hDEAD_BEEF;
    @(negedge clk);
    chk32("collide_old", rsp_instr, 32'h00E6_1000);
    $display("collision fetch addr=0000000c instr=%h", rsp_instr);
    cyc();
    fetch_check("collide_new", 32'd12, 32'hDEAD_BEEF, 1'b0);

    // Flush while stalled
    req_valid = 1'b1; req_addr = 32'd0; rsp_ready = 1'b0;
    cyc();
    req_addr = 32'd4; flush = 1'b1;
    @(negedge clk);
    chk1("flush_ready", req_ready, 1'b0);
    chk1("flush_pre_valid", rsp_valid, 1'b1);
    cyc();
    flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    chk1("flush_valid", rsp_valid, 1'b0);
    cyc();
    @(negedge clk);
    chk1("flush_no_dup", rsp_valid, 1'b0);
    $display("flush dropped stalled response");
    cyc();

    // Reset while a response is held
    req_valid = 1'b1; req_addr = 32'd4; rsp_ready = 1'b0;
    cyc();
    req_valid = 1'b0;
    @(negedge clk);
    chk1("rst_pre_valid", rsp_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk1("rst_async_valid", rsp_valid, 1'b0);
    chk32("rst_async_instr", rsp_instr, NOP);
    chk32("rst_async_addr", rsp_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    fetch_check("rst_retained", 32'd0, 32'h0062_0000, 1'b0);

    // Random traffic against the reference model
    for (int i = 0; i < int'(DEP); i++) prog(32'(i * 4), $urandom);
    rsp_ready = 1'b1;
    cyc();
    pv = 1'b0; pi = '0; pa = '0; pe = 1'b0;
    for (int c = 0; c < 400; c++) begin
      int unsigned m;
      m = $urandom_range(0, 9);
      req_valid = ($urandom_range(0, 3) != 0);
      if (m < 8)       req_addr = 32'($urandom_range(0, DEP - 1) * 4);
      else if (m == 8) req_addr = 32'($urandom_range(0, DEP - 1) * 4 + $urandom_range(1, 3));
      else             req_addr = 32'($urandom_range(DEP, 5000) * 4);
      rsp_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 9) == 0);
      prog_we   = ($urandom_range(0, 3) == 0);
      prog_addr = (m == 9) ? 32'($urandom_range(0, 300) * 4) : 32'($urandom_range(0, DEP - 1) * 4);
      prog_data = $urandom;
      @(negedge clk);
      exp_rdy = !flush && (!pv || rsp_ready);
      chk1("rnd_ready", req_ready, exp_rdy);
      chk1("rnd_valid", rsp_valid, pv);
      if (pv) begin
        chk32("rnd_instr", rsp_instr, pi);
        chk32("rnd_addr", rsp_addr, pa);
        chk1("rnd_err", rsp_err, pe);
        if (rsp_ready && !flush)
          $display("rnd rsp addr=%h instr=%h err=%b", rsp_addr, rsp_instr, rsp_err);
      end
      @(posedge clk);
      // Transaction-level model update for this edge: read old contents first
      if (req_valid && exp_rdy) begin
        pv = 1'b1;
        pa = req_addr;
        pe = !addr_ok(req_addr);
        pi = pe ? NOP : mdl_mem[req_addr / 4];
      end else if (flush || rsp_ready) begin
        pv = 1'b0;
      end
      if (prog_we && addr_ok(prog_addr)) mdl_mem[prog_addr / 4] = prog_data;
      #1;
    end
    req_valid = 1'b0; prog_we = 1'b0; flush = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
